config_stream_loader: RTL and testbench
=======================================

// Module: config_stream_loader
// PURPOSE
//  Upstream feeder of the tile configuration bus. Accepts a byte stream (host/flash
//  bridge, valid/ready) and unpacks it into {config_addr, config_data} writes that
//  are broadcast to every tile (CLB, switch box, connect boxes).
//  Tile enables decode the address combinationally, so an idle address that no tile
//  matches is always driven between writes.
// PARAMETERS
//  IDLE_ADDR   32'hFFFF_FFFF  address driven when not writing; tile_id 16'hFFFF is reserved
//  CNT_W       16             width of the record counter and the words_written output
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  in_data        in   8   stream byte
//  in_valid       in   1   in_data valid
//  in_ready       out  1   loader accepts a byte this cycle (accept = in_valid & in_ready)
//  start          in   1   re-arm after done (ignored in other states)
//  config_addr    out  32  {block_id[31:16], tile_id[15:0]}; IDLE_ADDR when idle
//  config_data    out  32  write payload; 0 when idle
//  busy           out  1   header or record partly received, or a write in progress
//  done           out  1   sticky; all records written
//  words_written  out CNT_W  count of writes issued since the last reset/start
// BEHAVIOUR
//  Stream format, little-endian: 4-byte record count N, then N records of 8 bytes
//   (addr[7:0]..addr[31:24], data[7:0]..data[31:24]). Only the low CNT_W bits of N are used.
//  Reset values: config_addr=IDLE_ADDR, config_data=0, in_ready=1, busy=0, done=0,
//   words_written=0, state=S_HDR, byte index=0.
//  FSM:
//   S_HDR   in_ready=1; shift in 4 bytes. On the 4th accepted byte: go to S_DONE if N==0,
//           otherwise load remaining=N and go to S_REC.
//   S_REC   in_ready=1; shift in 8 bytes. On the 8th accepted byte go to S_WRITE.
//   S_WRITE in_ready=0; config_addr/config_data carry the record for exactly 1 cycle;
//           words_written+=1 and remaining-=1. Next state is S_DONE if remaining becomes 0,
//           otherwise S_REC.
//   S_DONE  in_ready=0, done=1, outputs idle. start=1 clears done and words_written
//           and goes to S_HDR.
//  Latency: the write is visible in the cycle after the accept of the 8th byte.
//   Throughput is one record per 9 cycles (one mandatory bubble).
//  busy=1 in S_WRITE and in S_HDR/S_REC when byte index!=0; otherwise busy=0.
//  Gaps (in_valid=0) at any byte position stall without loss. Bytes are held, never reordered.
//  In every cycle outside S_WRITE: config_addr==IDLE_ADDR and config_data==0.
//  There is never a glitching partial address, because outputs are registered.
//  Reset mid-record or mid-header discards the partial bytes and returns to S_HDR.
//   No write is issued.
//  Reset during S_WRITE takes priority: the next cycle shows idle outputs.
//  start outside S_DONE has no effect. start and in_valid in S_DONE: the byte is not
//   accepted that cycle (in_ready=0).
//  words_written saturates at 2^CNT_W-1 and does not wrap.
// STRUCTURE
//  config_defs.vh: state encodings (S_HDR, S_REC, S_WRITE, S_DONE), HDR_BYTES=4, REC_BYTES=8,
//   CFG_IDLE_ADDR. These are shared with the tile config-enable decoders and the bench.
//  Sub-module cfg_byte_packer: 64-bit little-endian shift-in register with a 3-bit byte index
//   and a clear input. The FSM and counters stay in config_stream_loader.
// TESTING
//  1 Reset: hold reset 2 cycles -> config_addr=FFFF_FFFF, config_data=0, in_ready=1,
//    busy=0, done=0, words_written=0.
//  2 Single write: stream 01 00 00 00 | 03 00 07 00 05 00 00 00 -> exactly one cycle with
//    config_addr=0007_0003 and config_data=0000_0005. Then idle, done=1, words_written=1.
//    Check that a pe tile with tile_id=3 loads sb config 5.
//  3 Empty load: 00 00 00 00 -> done=1 the cycle after the 4th byte, with no non-idle
//    address ever driven.
//  4 Stalls: N=2 with in_valid toggling every other cycle -> two writes in stream order,
//    each 1 cycle wide, in_ready=0 on each write cycle, words_written=2.
//  5 Reset mid-record: header N=1 plus 5 record bytes, then reset -> no write issued.
//    A fresh full stream then produces its own single correct write.
//  6 Re-arm: in S_DONE offer bytes -> none accepted. Pulse start -> done=0,
//    words_written=0, and the next stream is parsed from its header.

Source files
------------

// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the configuration stream loader: FSM states,
// stream framing sizes and the reserved idle address that no tile decodes.
package config_stream_loader_pkg;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_REC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int HDR_BYTES = 4;
  localparam int REC_BYTES = 8;

  // tile_id 16'hFFFF is reserved, so this address never enables a tile
  localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

  // True when the byte at this index completes the header or a record
  function automatic logic isLastByte(input state_e s, input logic [2:0] idx);
    return ((s == S_HDR) && (idx == 3'(HDR_BYTES - 1))) ||
           ((s == S_REC) && (idx == 3'(REC_BYTES - 1)));
  endfunction

endpackage

// File: rtl/config_stream_loader_byte_packer.sv
// Little-endian byte packer: bytes shift in from the top so the first byte
// ends up in the least significant position. word_o is the 64-bit view that
// includes the byte being offered now, so the consumer can act on the last
// byte in the same cycle it is accepted.
module cfg_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic [2:0]  index_o
);

  logic [55:0] word_q;
  logic [2:0]  index_q;

  // Shift accepted bytes in and track how many of the current frame have arrived
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      index_q <= '0;
    end else begin
      if (shift_i) begin
        word_q <= {byte_i, word_q[55:8]};
      end
      if (clear_i) begin
        index_q <= '0;
      end else if (shift_i) begin
        index_q <= index_q + 3'd1;
      end
    end
  end

  assign word_o  = {byte_i, word_q};
  assign index_o = index_q;

endmodule

// File: rtl/config_stream_loader.sv
// Unpacks a valid/ready byte stream (record count, then addr/data records)
// into single-cycle {config_addr, config_data} writes broadcast to all tiles.
// Outputs are registered so tiles never see a partially assembled address.
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR = CFG_IDLE_ADDR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  output logic [31:0]      config_addr,
  output logic [31:0]      config_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_written
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] wordsWritten_q, wordsWritten_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic        accept;
  logic        lastByte;
  logic        packClear;
  logic [63:0] packWord;
  logic [2:0]  packIndex;

  assign in_ready = (state_q == S_HDR) || (state_q == S_REC);
  assign accept   = in_valid && in_ready;
  assign lastByte = accept && isLastByte(state_q, packIndex);

  cfg_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (packClear),
    .shift_i (accept),
    .byte_i  (in_data),
    .word_o  (packWord),
    .index_o (packIndex)
  );

  // Register FSM state, counters and the write-bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_HDR;
      remaining_q    <= '0;
      wordsWritten_q <= '0;
      addr_q         <= IDLE_ADDR;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      wordsWritten_q <= wordsWritten_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
    end
  end

  // Next-state logic; the bus defaults to idle so only S_WRITE shows a record
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    wordsWritten_d = wordsWritten_q;
    addr_d         = IDLE_ADDR;
    data_d         = '0;
    packClear      = 1'b0;
    case (state_q)
      S_HDR: begin
        if (lastByte) begin
          packClear = 1'b1;
          if (packWord[32 +: CNT_W] == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = packWord[32 +: CNT_W];
            state_d     = S_REC;
          end
        end
      end
      S_REC: begin
        if (lastByte) begin
          addr_d  = packWord[31:0];
          data_d  = packWord[63:32];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (wordsWritten_q != '1) begin
          wordsWritten_d = wordsWritten_q + CNT_W'(1);
        end
        state_d = (remaining_q == CNT_W'(1)) ? S_DONE : S_REC;
      end
      S_DONE: begin
        if (start) begin
          wordsWritten_d = '0;
          state_d        = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  assign config_addr   = addr_q;
  assign config_data   = data_q;
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q == S_WRITE) || (in_ready && (packIndex != 3'd0));
  assign words_written = wordsWritten_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: directed scenarios plus randomized streams,
// checked against a record-level model of the expected bus writes.
module tb_config_stream_loader;
  import config_stream_loader_pkg::*;

  localparam logic [31:0] IDLE = CFG_IDLE_ADDR;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic [15:0] words_written;

  int nAssert = 0;
  int nFail   = 0;

  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  logic        obsReady[$];
  int          obsBase = 0;
  int          widthErr = 0;
  int          idleDataErr = 0;
  logic        prevWrite = 1'b0;

  logic [31:0] expAddr[$];
  logic [31:0] expData[$];

  logic [31:0] tileCfg = 32'h0;

  always #5 clk = ~clk;

  config_stream_loader #(.IDLE_ADDR(32'hFFFF_FFFF), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .start         (start),
    .config_addr   (config_addr),
    .config_data   (config_data),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  // Record every non-idle bus cycle and flag multi-cycle writes or dirty idle data
  always @(negedge clk) begin
    if (config_addr !== IDLE) begin
      obsAddr.push_back(config_addr);
      obsData.push_back(config_data);
      obsReady.push_back(in_ready);
      if (prevWrite) widthErr++;
      prevWrite = 1'b1;
    end else begin
      prevWrite = 1'b0;
      if (config_data !== 32'h0) idleDataErr++;
    end
  end

  // A pe tile with tile_id 3 latches whatever write is addressed to it
  always @(posedge clk) begin
    if (config_addr !== IDLE && config_addr[15:0] == 16'h0003) tileCfg <= config_data;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one byte after an optional idle gap and hold it until accepted
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCnt;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    waitCnt  = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("acceptTimeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendWord32(input logic [31:0] w, input int gapMode);
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 3));
      applyStimulus(8'((w >> (8 * k)) & 32'hFF), gap);
    end
  endtask

  // Build a random stream, queue its expected writes and send it
  task automatic sendRandomStream(input int n, input int gapMode);
    logic [31:0] a;
    logic [31:0] d;
    sendWord32(32'(n), gapMode);
    for (int r = 0; r < n; r++) begin
      a = $urandom;
      if (a[15:0] == 16'hFFFF) a[15:0] = 16'h0000;
      d = $urandom;
      expAddr.push_back(a);
      expData.push_back(d);
      sendWord32(a, gapMode);
      sendWord32(d, gapMode);
    end
  endtask

  task automatic waitDone();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    #1;
    checkOutput("doneReached", {63'b0, done}, 64'd1);
  endtask

  // Compare observed writes since the last call against the model queue
  task automatic compareWrites(input string tag);
    int nObs;
    nObs = obsAddr.size() - obsBase;
    checkOutput({tag, "_count"}, 64'(nObs), 64'(expAddr.size()));
    for (int i = 0; i < nObs && i < expAddr.size(); i++) begin
      checkOutput({tag, "_addr"}, {32'b0, obsAddr[obsBase + i]}, {32'b0, expAddr[i]});
      checkOutput({tag, "_data"}, {32'b0, obsData[obsBase + i]}, {32'b0, expData[i]});
      checkOutput({tag, "_readyLow"}, {63'b0, obsReady[obsBase + i]}, 64'd0);
    end
    obsBase = obsAddr.size();
    expAddr.delete();
    expData.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] single[12];
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstAddr", {32'b0, config_addr}, {32'b0, IDLE});
    checkOutput("rstData", {32'b0, config_data}, 64'd0);
    checkOutput("rstReady", {63'b0, in_ready}, 64'd1);
    checkOutput("rstBusy", {63'b0, busy}, 64'd0);
    checkOutput("rstDone", {63'b0, done}, 64'd0);
    checkOutput("rstWords", {48'b0, words_written}, 64'd0);

    // Single directed write, including one-cycle latency after the 8th record byte
    single = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h07, 8'h00,
               8'h05, 8'h00, 8'h00, 8'h00};
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) applyStimulus(single[i], 0);
    @(negedge clk);
    checkOutput("singleAddr", {32'b0, config_addr}, 64'h0007_0003);
    checkOutput("singleData", {32'b0, config_data}, 64'h0000_0005);
    checkOutput("singleReady", {63'b0, in_ready}, 64'd0);
    checkOutput("singleBusy", {63'b0, busy}, 64'd1);
    @(negedge clk); #1;
    checkOutput("singleIdle", {32'b0, config_addr}, {32'b0, IDLE});
    checkOutput("singleDone", {63'b0, done}, 64'd1);
    checkOutput("singleWords", {48'b0, words_written}, 64'd1);
    checkOutput("tile3Cfg", {32'b0, tileCfg}, 64'd5);
    expAddr.push_back(32'h0007_0003);
    expData.push_back(32'h0000_0005);
    compareWrites("single");

    // Empty load
    pulseStart();
    @(negedge clk);
    checkOutput("startDone", {63'b0, done}, 64'd0);
    checkOutput("startWords", {48'b0, words_written}, 64'd0);
    @(posedge clk); #1;
    sendWord32(32'd0, 0);
    @(negedge clk); #1;
    checkOutput("emptyDone", {63'b0, done}, 64'd1);
    compareWrites("empty");

    // Stalls: in_valid toggles every other cycle
    pulseStart();
    sendRandomStream(2, 1);
    waitDone();
    compareWrites("stall");
    checkOutput("stallWidth", 64'(widthErr), 64'd0);
    checkOutput("stallWords", {48'b0, words_written}, 64'd2);

    // Reset in the middle of a record discards it
    pulseStart();
    sendWord32(32'd1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 0);
    @(negedge clk);
    checkOutput("midRecBusy", {63'b0, busy}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", {63'b0, in_ready}, 64'd1);
    checkOutput("midRstBusy", {63'b0, busy}, 64'd0);
    checkOutput("midRstDone", {63'b0, done}, 64'd0);
    compareWrites("midRst");
    @(posedge clk); #1;
    sendRandomStream(1, 2);
    waitDone();
    compareWrites("afterRst");
    checkOutput("afterRstWords", {48'b0, words_written}, 64'd1);

    // Re-arm: bytes offered in S_DONE are refused, also in the start cycle
    @(posedge clk); #1;
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("doneRefuse", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("startRefuse", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rearmDone", {63'b0, done}, 64'd0);
    checkOutput("rearmWords", {48'b0, words_written}, 64'd0);
    checkOutput("rearmReady", {63'b0, in_ready}, 64'd1);
    checkOutput("rearmBusy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    sendRandomStream(3, 2);
    waitDone();
    compareWrites("rearm");
    checkOutput("rearmWordsEnd", {48'b0, words_written}, 64'd3);

    // Randomized streams with random gaps
    for (int t = 0; t < 4; t++) begin
      pulseStart();
      n = int'($urandom_range(1, 5));
      sendRandomStream(n, 2);
      waitDone();
      compareWrites("rand");
      checkOutput("randWords", {48'b0, words_written}, 64'(n));
    end

    checkOutput("writeWidth", 64'(widthErr), 64'd0);
    checkOutput("idleData", 64'(idleDataErr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
